// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundle of the two client request ports and the scratch-memory
//            command/return signals used by mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
);
    // Client 0 / client 1 request side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;

    // Client 0 / client 1 response side
    logic              gnt0;
    logic              gnt1;
    logic              err0;
    logic              err1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // Scratch memory command and registered read return
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_wr_en, mem_rd_en, mem_addr, mem_data_in,
        input  mem_data_out
    );

    // Client and memory view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, err0, err1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_data_in,
        output mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-client round-robin arbiter and sequencer in front of a
//            single-port synchronous scratch memory. Serialises client
//            requests into one-cycle memory commands, rejects out-of-range
//            addresses and returns read data with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4
) (
    input  wire logic         iclk,
    input  wire logic         irst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_ACCESS  = 2'd1;
    localparam logic [1:0]        c_RD_WAIT = 2'd2;
    localparam logic [ADDR_W-1:0] c_DEPTH   = ADDR_W'(DEPTH);

    logic [1:0]        r_state;
    logic              r_prio;   // port that wins the next contested grant
    logic              r_win;    // port owning the command in flight
    logic              r_rd;     // command in flight is an in-range read

    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_oor;

    // Winner selection: a lone requester wins, otherwise the prio port wins
    assign w_any   = bus.req0 | bus.req1;
    assign w_win   = (bus.req0 & bus.req1) ? r_prio : bus.req1;
    assign w_we    = w_win ? bus.we1    : bus.we0;
    assign w_addr  = w_win ? bus.addr1  : bus.addr0;
    assign w_wdata = w_win ? bus.wdata1 : bus.wdata0;
    assign w_oor   = (w_addr >= c_DEPTH);

    // Sequencer: grant and memory command are registered at the sampling
    // edge so they are visible for exactly the ACCESS cycle
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state         <= c_IDLE;
            r_prio          <= 1'b0;
            r_win           <= 1'b0;
            r_rd            <= 1'b0;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.err0        <= 1'b0;
            bus.err1        <= 1'b0;
            bus.rvalid0     <= 1'b0;
            bus.rvalid1     <= 1'b0;
            bus.rdata0      <= '0;
            bus.rdata1      <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_in <= '0;
        end else begin
            // Pulses default low; address/data registers hold their value
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.rvalid0   <= 1'b0;
            bus.rvalid1   <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_win    <= w_win;
                        r_rd     <= ~w_we & ~w_oor;
                        bus.gnt0 <= ~w_win;
                        bus.gnt1 <= w_win;
                        if (w_oor) begin
                            bus.err0 <= ~w_win;
                            bus.err1 <= w_win;
                        end else if (w_we) begin
                            bus.mem_wr_en   <= 1'b1;
                            bus.mem_addr    <= w_addr;
                            bus.mem_data_in <= w_wdata;
                        end else begin
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= w_addr;
                        end
                        // Priority only moves when both ports competed
                        if (bus.req0 & bus.req1) begin
                            r_prio <= ~w_win;
                        end
                        r_state <= c_ACCESS;
                    end
                end

                c_ACCESS: begin
                    r_state <= r_rd ? c_RD_WAIT : c_IDLE;
                end

                c_RD_WAIT: begin
                    // Memory output is valid in this cycle; capture it
                    if (r_win) begin
                        bus.rdata1  <= bus.mem_data_out;
                        bus.rvalid1 <= 1'b1;
                    end else begin
                        bus.rdata0  <= bus.mem_data_out;
                        bus.rvalid0 <= 1'b1;
                    end
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
